// File: rtl/i2c_codec_target_if.sv
// Register-write and CODEC-state signals published by the WM8731 control-port target.
interface i2c_codec_target_if;
  logic        wr_valid;
  logic [6:0]  wr_addr;
  logic [8:0]  wr_data;
  logic [89:0] regs_flat;
  logic        codec_active;
  logic        busy;

  modport slave  (output wr_valid, wr_addr, wr_data, regs_flat, codec_active, busy);
  modport master (input  wr_valid, wr_addr, wr_data, regs_flat, codec_active, busy);
endinterface

// File: rtl/i2c_codec_target.sv
// I2C write-only target modelling the WM8731 2-wire control port.
// Accepts {addr,0}, {reg,d8}, d[7:0], ACKs each byte and commits into a 10 x 9-bit register file.
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i2c_sclk,
  inout  wire               i2c_sdat,
  i2c_codec_target_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_BYTE, S_BYTE_ACK, S_IGNORE
  } state_t;

  state_t      state;
  logic        scl_s1, scl_s2, scl_h;
  logic        sda_s1, sda_s2, sda_h;
  logic [3:0]  bit_cnt;
  logic        byte_cnt;
  logic [7:0]  shreg;
  logic [7:0]  hi_byte;
  logic        sda_drive;
  logic        wr_valid_q;
  logic [6:0]  wr_addr_q;
  logic [8:0]  wr_data_q;
  logic        busy_q;
  logic [8:0]  regs [10];
  logic [89:0] regs_flat_c;

  logic scl_rise, scl_fall, start_det, stop_det;

  // Synchronizers idle high so a released bus after reset does not look like a START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_h <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_h <= 1'b1;
    end else begin
      scl_s1 <= i2c_sclk; scl_s2 <= scl_s1; scl_h <= scl_s2;
      sda_s1 <= i2c_sdat; sda_s2 <= sda_s1; sda_h <= sda_s2;
    end
  end

  assign scl_rise  =  scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 &  scl_h;
  assign start_det =  scl_s2 &  sda_h & ~sda_s2;
  assign stop_det  =  scl_s2 & ~sda_h &  sda_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      byte_cnt   <= 1'b0;
      shreg      <= '0;
      hi_byte    <= '0;
      sda_drive  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      for (int unsigned i = 0; i < 10; i++) regs[i] <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (start_det) begin
        state     <= S_ADDR;
        bit_cnt   <= '0;
        byte_cnt  <= 1'b0;
        sda_drive <= 1'b0;
        busy_q    <= 1'b1;
      end else if (stop_det) begin
        state     <= S_IDLE;
        bit_cnt   <= '0;
        sda_drive <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_BYTE: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= {shreg[6:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              // Address mismatch (including read requests) leaves SDA released: a NACK.
              if (state == S_BYTE) begin
                sda_drive <= 1'b1;
                state     <= S_BYTE_ACK;
              end else if (shreg == {DEV_ADDR, 1'b0}) begin
                sda_drive <= 1'b1;
                state     <= S_ADDR_ACK;
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              sda_drive <= 1'b0;
              bit_cnt   <= '0;
              state     <= S_BYTE;
            end
          end
          S_BYTE_ACK: begin
            if (scl_fall) begin
              sda_drive <= 1'b0;
              bit_cnt   <= '0;
              if (!byte_cnt) begin
                hi_byte  <= shreg;
                byte_cnt <= 1'b1;
                state    <= S_BYTE;
              end else begin
                wr_valid_q <= 1'b1;
                wr_addr_q  <= hi_byte[7:1];
                wr_data_q  <= {hi_byte[0], shreg};
                if (hi_byte[7:1] < 7'd10)
                  regs[hi_byte[4:1]] <= {hi_byte[0], shreg};
                else if (hi_byte[7:1] == 7'h0F)
                  for (int unsigned i = 0; i < 10; i++) regs[i] <= '0;
                state <= S_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    regs_flat_c = '0;
    for (int unsigned i = 0; i < 10; i++) regs_flat_c[9*i +: 9] = regs[i];
  end

  assign i2c_sdat         = (sda_drive && reset_n) ? 1'b0 : 1'bz;
  assign bus.wr_valid     = wr_valid_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.regs_flat    = regs_flat_c;
  assign bus.codec_active = regs[9][0];
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Scoreboard bench for i2c_codec_target: a bit-banged I2C master drives writes,
// a register-file model predicts commits, and a monitor checks every wr_valid pulse.
module tb_i2c_codec_target;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_codec_target_if bus ();

  i2c_codec_target #(.DEV_ADDR(7'h1A)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i2c_sclk (scl),
    .i2c_sdat (sda),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  a;
    logic [8:0]  d;
    logic [89:0] regs;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  exp_regs [10];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int          q_clk = 32;

  function automatic logic [89:0] model_flat();
    logic [89:0] f;
    f = '0;
    for (int i = 0; i < 10; i++) f[9*i +: 9] = exp_regs[i];
    return f;
  endfunction

  function automatic void model_write(input logic [6:0] a, input logic [8:0] d);
    if (a < 7'd10) exp_regs[a] = d;
    else if (a == 7'h0F) for (int i = 0; i < 10; i++) exp_regs[i] = '0;
  endfunction

  task automatic chk(input string name, input logic [89:0] act, input logic [89:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic qwait();
    repeat (q_clk) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; qwait();
    scl = 1'b1;       qwait();
    m_sda_low = 1'b1; qwait();
    scl = 1'b0;       qwait();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; qwait();
    scl = 1'b1;       qwait();
    m_sda_low = 1'b0; qwait();
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = !b; qwait();
    scl = 1'b1;     qwait(); qwait();
    scl = 1'b0;     qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda_low = 1'b0; qwait();
    scl = 1'b1;       qwait();
    acked = (sda === 1'b0);
    qwait();
    scl = 1'b0;       qwait();
  endtask

  // Send n bytes (address first) framed by START/STOP; an ACKed 3rd byte commits.
  task automatic xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input int n);
    logic [7:0] bs [4];
    logic       dev, acked;
    exp_t       e;
    bs  = '{b0, b1, b2, b3};
    dev = (b0 == 8'h34);
    i2c_start();
    chk("busy_after_start", bus.busy, 1);
    for (int i = 0; i < n && (i == 0 || dev); i++) begin
      if (i == 2 && dev) begin
        model_write(b1[7:1], {b1[0], b2});
        e.a = b1[7:1]; e.d = {b1[0], b2}; e.regs = model_flat();
        exp_q.push_back(e);
      end
      send_byte(bs[i], acked);
      chk($sformatf("ack_byte%0d_%02h", i, bs[i]), acked, dev && i < 3);
    end
    i2c_stop();
    chk("busy_after_stop", bus.busy, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_commit: got addr %0h data %0h, required no commit",
                   bus.wr_addr, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.wr_addr, e.a);
          chk("wr_data", bus.wr_data, e.d);
          chk("regs_flat_at_commit", bus.regs_flat, e.regs);
          chk("codec_active_at_commit", bus.codec_active, e.regs[81]);
        end
      end
    end
  end

  logic [15:0] init_seq [11] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479,
                                 16'h0679, 16'h08D4, 16'h0A06, 16'h1020, 16'h0C00, 16'h1201};

  initial begin : stim
    logic        acked;
    logic [7:0]  b1;
    logic [3:0]  ra;
    logic [8:0]  rd;
    for (int i = 0; i < 10; i++) exp_regs[i] = '0;

    repeat (4) @(negedge clk);
    chk("reset_wr_valid", bus.wr_valid, 0);
    chk("reset_wr_addr", bus.wr_addr, 0);
    chk("reset_wr_data", bus.wr_data, 0);
    chk("reset_regs_flat", bus.regs_flat, 0);
    chk("reset_codec_active", bus.codec_active, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_sda_released", sda, 1);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);

    // Single power-down register write at SCL = clk/128
    xfer(8'h34, 8'h0C, 8'h10, 8'h00, 3);
    chk("reg6_after_0C10", bus.regs_flat[62:54], 9'h010);

    // Aborted write, then the complete one
    xfer(8'h34, 8'h12, 8'h00, 8'h00, 2);
    chk("reg9_after_abort", bus.regs_flat[89:81], 9'h000);
    xfer(8'h34, 8'h12, 8'h01, 8'h00, 3);
    chk("codec_active_after_1201", bus.codec_active, 1);

    // Full init sequence at a faster SCL
    q_clk = 8;
    foreach (init_seq[k]) xfer(8'h34, init_seq[k][15:8], init_seq[k][7:0], 8'h00, 3);
    chk("init_reg0", bus.regs_flat[8:0], 9'h017);
    chk("init_reg4", bus.regs_flat[44:36], 9'h0D4);
    chk("init_reg8", bus.regs_flat[80:72], 9'h020);
    chk("init_reg6", bus.regs_flat[62:54], 9'h000);
    chk("init_codec_active", bus.codec_active, 1);

    // Foreign address and read request are NACKed and change nothing
    q_clk = 32;
    xfer(8'h36, 8'h0C, 8'hFF, 8'h00, 3);
    xfer(8'h35, 8'h0C, 8'hFF, 8'h00, 3);
    chk("regs_after_bad_addr", bus.regs_flat, model_flat());

    // Reset register with a trailing 4th byte
    xfer(8'h34, 8'h1E, 8'h00, 8'h55, 4);
    chk("regs_after_1E00", bus.regs_flat, 0);

    // Randomized writes, some to a foreign address
    q_clk = 8;
    for (int k = 0; k < 8; k++) begin
      ra = 4'($urandom_range(0, 15));
      rd = 9'($urandom_range(0, 511));
      b1 = {3'b000, ra, rd[8]};
      xfer(($urandom_range(0, 3) == 0) ? 8'h36 : 8'h34, b1, rd[7:0], 8'h00, 3);
    end
    chk("regs_after_random", bus.regs_flat, model_flat());
    xfer(8'h34, 8'h04, 8'h55, 8'h00, 3);

    // Asynchronous reset in bit 4 of byte 2
    q_clk = 32;
    i2c_start();
    send_byte(8'h34, acked);
    chk("ack_before_reset", acked, 1);
    for (int i = 7; i >= 4; i--) send_bit(b1[i]);
    reset_n = 1'b0;
    #1;
    m_sda_low = 1'b0;
    #1;
    chk("midreset_sda_released", sda, 1);
    chk("midreset_regs_flat", bus.regs_flat, 0);
    chk("midreset_wr_addr", bus.wr_addr, 0);
    chk("midreset_wr_data", bus.wr_data, 0);
    chk("midreset_busy", bus.busy, 0);
    for (int i = 0; i < 10; i++) exp_regs[i] = '0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    scl = 1'b1;
    qwait();
    xfer(8'h34, 8'h00, 8'h17, 8'h00, 3);
    chk("reg0_after_reset", bus.regs_flat[8:0], 9'h017);

    repeat (20) @(negedge clk);
    chk("pending_commits", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2c_codec_target.md
# i2c_codec_target

I2C target (slave) model of the WM8731 audio CODEC's 2-wire control port. It receives the 3-byte register writes a CODEC configuration master emits: device address, then {reg[6:0], data[8]}, then data[7:0]. It ACKs them, commits the write into a 9-bit register file, and exposes the resulting CODEC state. It stands in for the physical CODEC in FPGA loopback and simulation of the audio configuration path.

## Interface
- `DEV_ADDR`, 7'h1A: 7-bit target address. The write address byte is 8'h34.
- `clk` input 1: system clock. Must be at least 16x the SCL frequency.
- `reset_n` input 1: asynchronous, active-low reset.
- `i2c_sclk` input 1: I2C clock from the master.
- `i2c_sdat` inout 1: open-drain data line. The block drives only 1'b0 or 1'bz.
- `wr_valid` output 1: one-cycle pulse when a register write commits.
- `wr_addr` output 7: register address of the committed write. Held until the next commit.
- `wr_data` output 9: data of the committed write. Held until the next commit.
- `regs_flat` output 90: registers 0..9, with reg n at bits [9n+8:9n].
- `codec_active` output 1: reg 9 bit 0 (active control).
- `busy` output 1: high from the detected START to the detected STOP.

## Operation
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchronizer plus one history flop.
  - Edges are derived from the history flop versus the synchronized value.
- Bus conditions:
  - START: synced SDA falls while synced SCL is high. It is valid in any state and acts as a repeated START mid-transfer.
  - STOP: synced SDA rises while synced SCL is high. It returns the FSM to IDLE from any state.
- Bit handling:
  - Bits are sampled on a detected SCL rise, MSB first, into an 8-bit shift register.
  - A 4-bit bit counter runs 0..8; bit 8 is the ACK slot.
- FSM states: IDLE, ADDR, ADDR_ACK, BYTE, BYTE_ACK, IGNORE.
  - IDLE -> ADDR on START. The bit counter and byte counter are cleared.
  - ADDR -> ADDR_ACK after 8 bits, when the byte equals {DEV_ADDR, 1'b0}.
  - ADDR -> IGNORE after 8 bits on any other byte, including a read request {DEV_ADDR, 1'b1}. SDA is never driven in that case, so the master sees a NACK.
  - ADDR_ACK -> BYTE at the SCL fall that ends the ACK bit.
  - BYTE -> BYTE_ACK after 8 bits.
  - BYTE_ACK after byte 1: store the byte as hi_byte, then go to BYTE.
  - BYTE_ACK after byte 2: commit, then go to IGNORE.
  - IGNORE: no SDA drive until STOP or START. Any 4th or later data byte is therefore NACKed.
- ACK drive:
  - SDA is pulled low on the clk after the detected SCL fall that ends bit 7.
  - SDA is released on the clk after the detected SCL fall that ends the ACK bit.
  - SDA is never driven while SCL is high except during the ACK bit.
- Commit: `wr_addr`=hi_byte[7:1] and `wr_data`={hi_byte[0], byte2}, with `wr_valid`=1 for one cycle.
  - Address 0..9: the register is written.
  - Address 7'h0F (reset register, any data): all of regs 0..9 clear to 0.
  - Any other address: `wr_valid` still pulses, but the register file is unchanged.
- Abort: a STOP or START before the commit discards the partial transfer. No `wr_valid`, no register change.

## Timing
- Reset values: `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `regs_flat`=0, `codec_active`=0, `busy`=0, SDA released (z). The FSM and all counters go to IDLE/0.
- Synchronizer latency: a pin edge is detected 3 clk after it occurs. START and STOP take effect on that detection cycle.
- `busy` rises the cycle after the detected START and falls the cycle after the detected STOP.
- Commit timing:
  - `wr_valid` is asserted on the clk after the detected SCL fall that ends the 3rd ACK, simultaneous with the SDA release.
  - `regs_flat` and `codec_active` show the new value in that same cycle.
- Simultaneous START/STOP and an SCL edge: this cannot occur legally because SCL is high. The START/STOP has priority.
- Asynchronous reset mid-byte: SDA releases immediately (combinational from `reset_n`). The registers clear. After reset deasserts, the FSM waits in IDLE for a fresh START.

## Test plan
- Master writes 8'h34, 16'h0C10 at SCL = clk/128:
  - Three ACKs are seen (SDA low at each 9th SCL rise).
  - `wr_valid` pulses once with `wr_addr`=7'h06 and `wr_data`=9'h010.
  - reg 6 reads 9'h010.
- The full 11-entry WM8731 init sequence, ending with 16'h1201:
  - reg 0=9'h017, reg 4=9'h0D4, reg 8=9'h020, reg 6=9'h000 after the second power write.
  - `codec_active`=1 at the end.
- Address byte 8'h36, then 8'h35:
  - No ACK in either case, no `wr_valid`, registers unchanged.
  - `busy` follows START/STOP.
- 8'h34, 8'h12, then STOP:
  - Two ACKs, no commit, reg 9 unchanged.
  - A following complete write of 16'h1201 succeeds.
- Registers preloaded, then write 16'h1E00:
  - `wr_addr`=7'h0F, and `regs_flat`=0 on the commit cycle.
  - A 4th trailing byte is NACKed.
- `reset_n` asserted during bit 4 of byte 2:
  - SDA is released and outputs return to their reset values.
  - The next full write 16'h0017 commits correctly.
